// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
package bus_arbiter_pkg;

    localparam int unsigned DATA_W              = 16;
    localparam int unsigned ADDR_W              = 16;
    localparam int unsigned DEFAULT_WAIT_STATES = 1;

    // Master IDs
    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick; on a tie the master that was not last served wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant_valid,
    output logic winner
);

    // Tie goes to !last, otherwise the single requester wins.
    always_comb begin
        grant_valid = req0 | req1;
        winner      = (req0 & req1) ? ~last : req1;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the 16-bit memory bus: registered, wait-state stretched accesses with one-cycle ack.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_STATES = DEFAULT_WAIT_STATES,
    parameter int unsigned CW          = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic [15:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic [15:0] m1_rdata,
    output logic        m1_ack,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic        owner,
    output logic        busy
);

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic                owner_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [DATA_W-1:0]   rd0_d, rd1_d;
    logic                ack0_d, ack1_d;
    logic                read_d, write_d;
    logic                busy_d;
    logic                grant_valid;
    logic                winner;
    logic                sel_we;

    rr_pick2 u_pick (
        .req0        (m0_req),
        .req1        (m1_req),
        .last        (last_q),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    assign sel_we = (winner == M_DMA) ? m1_we : m0_we;

    // Next-state and next-output logic; everything holds unless the state says otherwise.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        we_d    = we_q;
        owner_d = owner;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        rd0_d   = m0_rdata;
        rd1_d   = m1_rdata;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        read_d  = mem_read;
        write_d = mem_write;
        busy_d  = busy;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = ACCESS;
                    cnt_d   = CW'(WAIT_STATES);
                    owner_d = winner;
                    we_d    = sel_we;
                    addr_d  = (winner == M_DMA) ? m1_addr  : m0_addr;
                    wdata_d = (winner == M_DMA) ? m1_wdata : m0_wdata;
                    read_d  = ~sel_we;
                    write_d = sel_we;
                    busy_d  = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = DONE;
                    last_d  = owner;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (!we_q) begin
                        if (owner == M_DMA) rd1_d = mem_rdata;
                        else                rd0_d = mem_rdata;
                    end
                    if (owner == M_DMA) ack1_d = 1'b1;
                    else                ack0_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            owner     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            we_q      <= we_d;
            owner     <= owner_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            m0_rdata  <= rd0_d;
            m1_rdata  <= rd1_d;
            m0_ack    <= ack0_d;
            m1_ack    <= ack1_d;
            mem_read  <= read_d;
            mem_write <= write_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter for the single 16-bit memory bus.
- Master 0 is the stack CPU datapath; master 1 is the DMA/monitor port.
- Arbitration is round-robin. Each access is registered, stretched by a programmable wait-state count, and completed with a one-cycle ack pulse.
- Sits between the masters and the memory/IO decode. Only one of mem_read/mem_write is ever driven at a time.

Parameters:
- WAIT_STATES, 1, extra cycles mem_read/mem_write are held beyond the first (0..15).
- CW, 4, width of the wait-state counter; must satisfy 2^CW > WAIT_STATES.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- m0_req  in  1  master 0 request; held high until m0_ack seen.
- m0_we  in  1  master 0 direction: 1 = write, 0 = read.
- m0_addr  in  16  master 0 address.
- m0_wdata  in  16  master 0 write data.
- m0_rdata  out  16  master 0 read data; valid while m0_ack = 1.
- m0_ack  out  1  master 0 completion pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: same as master 0, for master 1.
- mem_addr  out  16  registered bus address.
- mem_wdata  out  16  registered bus write data.
- mem_rdata  in  16  bus read data, sampled on the last strobe cycle.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- owner  out  1  master currently or last granted.
- busy  out  1  high in ACCESS and DONE.

Behaviour:
- Reset (reset = 0, async): state = IDLE, cnt = 0, last = 1 (so m0 wins the first tie), owner = 0.
  - All outputs 0: mem_addr, mem_wdata, rdata, acks, strobes, busy.
  - Reset mid-access drops strobes immediately; the in-flight access is abandoned with no ack.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE, strobes low.
  - Exactly one req: grant that master.
  - Both req: grant the master != last.
  - On grant, at the same edge:
    - latch addr/wdata/we of the winner into mem_addr/mem_wdata;
    - owner <= winner; cnt <= WAIT_STATES;
    - go to ACCESS.
- ACCESS:
  - mem_read = !we_latched, mem_write = we_latched. Strobes are registered, asserted for exactly WAIT_STATES+1 cycles.
  - cnt != 0: decrement, stay in ACCESS.
  - cnt == 0:
    - read: capture mem_rdata into the owner's rdata register;
    - go to DONE; last <= owner.
  - mem_addr/mem_wdata stay stable for the whole ACCESS; master inputs are ignored after the grant edge.
- DONE:
  - Owner's ack = 1 for exactly one cycle; strobes low; busy = 1.
  - Next state IDLE unconditionally. This gives one turnaround cycle with no strobe between back-to-back accesses.
- rdata: holds its value until the next read by the same master. The write path leaves rdata unchanged.
- Latency, req sampled high in IDLE at edge E:
  - strobe high from E through E+WAIT_STATES;
  - ack high during the cycle after E+WAIT_STATES+1;
  - next grant possible at E+WAIT_STATES+3.
- Masters must deassert req on the edge that ends their ack cycle. A req still high in IDLE is treated as a new request.
- A req that drops before its grant is harmless: the master is simply not granted.
- A req arriving during ACCESS/DONE waits; nothing is queued beyond the level of req.
- Fairness: with both masters continuously requesting, grants alternate 0,1,0,1…
- Invariant: mem_read & mem_write never both 1; m0_ack & m1_ack never both 1.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE = 0, ACCESS = 1, DONE = 2 (2-bit);
  - master IDs M_CPU = 0, M_DMA = 1;
  - default WAIT_STATES.
- One natural sub-module, rr_pick2: combinational 2-way round-robin pick (req0, req1, last -> grant_valid, winner). It is reused later by the interrupt controller.

Test Plan:
- Reset then single read: WAIT_STATES = 1, m0 reads 16'h7e00, mem_rdata = 16'hBEEF.
  - mem_read high exactly 2 cycles with mem_addr = 16'h7e00;
  - m0_ack pulses 1 cycle later with m0_rdata = 16'hBEEF;
  - m1_ack stays 0.
- Single write: m1 writes 16'h1234 to 16'h7c00.
  - mem_write 2 cycles with mem_wdata = 16'h1234;
  - m1_ack 1 cycle; mem_read never asserted.
- Contention: m0 and m1 both request from reset, held continuously.
  - Grant order 0,1,0,1;
  - exactly one idle (no-strobe) cycle between accesses;
  - each ack matches owner.
- WAIT_STATES = 0 and 15:
  - strobe widths 1 and 16 cycles respectively;
  - ack 1 cycle after strobe drops.
- Async reset mid-ACCESS (reset low between clock edges):
  - strobes, busy and acks go 0 immediately;
  - after release the first grant goes to m0 even if both request.
- Input change after grant: toggle m0_addr/m0_wdata during ACCESS.
  - mem_addr/mem_wdata stay at the values latched at grant.
